// File: rtl/uart_rx_top.sv
// 8N1 UART receiver with centre sampling, last-good-byte register and
// ASCII-digit rate decode for the serial command path.
`timescale 1ns/1ps
module uart_rx_top #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RX,
    output logic       owSTART,
    output logic [7:0] owData,
    output logic [1:0] oRate
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    logic             rx_meta_q;
    logic             rx_sync_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             load_q;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            load_q  <= 1'b0;
            owSTART <= 1'b0;
            owData  <= 8'h00;
            oRate   <= 2'b00;
        end else begin
            load_q  <= 1'b0;
            owSTART <= (state_q != S_IDLE);

            // Commit one edge after a good stop bit; shift_q is stable until the next DATA phase.
            if (load_q) begin
                owData <= shift_q;
                if (shift_q >= 8'h30 && shift_q <= 8'h39) begin
                    oRate <= shift_q[1:0];
                end
            end

            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (!rx_sync_q) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        state_q <= rx_sync_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            bit_q   <= '0;
                            state_q <= S_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        load_q  <= rx_sync_q;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_top.sv
// Scoreboard bench for uart_rx_top: driver pushes the expected result of each
// frame, a monitor pops and checks whenever owSTART falls.
`timescale 1ns/1ps
module tb_uart_rx_top;

    localparam int unsigned CLK_FREQ  = 1_600_000;
    localparam int unsigned BAUD      = 100_000;
    localparam int unsigned CPB       = CLK_FREQ / BAUD;
    localparam int unsigned HALF      = CPB / 2;
    localparam int unsigned FRAME_LEN = HALF + 9 * CPB;

    typedef struct {
        logic [7:0] data;
        logic [1:0] rate;
        int         len;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       RX    = 1'b1;
    logic       owSTART;
    logic [7:0] owData;
    logic [1:0] oRate;

    exp_t       sb[$];
    int         n_cmp  = 0;
    int         n_err  = 0;
    logic [7:0] m_data = 8'h00;
    logic [1:0] m_rate = 2'b00;

    always #5 clk = ~clk;

    uart_rx_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk    (clk),
        .reset  (reset),
        .RX     (RX),
        .owSTART(owSTART),
        .owData (owData),
        .oRate  (oRate)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic hold_line(input logic v, input int n);
        RX = v;
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a byte with a good stop bit becomes the output; digits set the rate.
    task automatic model_frame(input logic [7:0] b, input logic stop_ok);
        exp_t e;
        if (stop_ok) begin
            m_data = b;
            if (int'(b) >= 48 && int'(b) <= 57) m_rate = 2'((int'(b) - 48) % 4);
        end
        e.data = m_data;
        e.rate = m_rate;
        e.len  = FRAME_LEN;
        sb.push_back(e);
        // A low stop bit is still low right after the stop sample, so it opens a
        // phantom start that dies at its half-bit check.
        if (!stop_ok) begin
            e.len = HALF;
            sb.push_back(e);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
        model_frame(b, stop);
        hold_line(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold_line(b[i], CPB);
        hold_line(stop, CPB);
        hold_line(1'b1, stop ? gap : gap + CPB);
    endtask

    task automatic glitch(input int n);
        exp_t e;
        e.data = m_data;
        e.rate = m_rate;
        e.len  = HALF;
        sb.push_back(e);
        hold_line(1'b0, n);
        hold_line(1'b1, CPB + HALF);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("pending_frames", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: one scoreboard entry per owSTART high period.
    initial begin
        logic prev = 1'b0;
        int   hi   = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0;
                hi   = 0;
            end else begin
                if (owSTART) hi++;
                if (prev && !owSTART) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_frame: got owData %0h with empty queue", owData);
                    end else begin
                        e = sb.pop_front();
                        chk("owData", 32'(owData), 32'(e.data));
                        chk("oRate", 32'(oRate), 32'(e.rate));
                        chk("busy_len", 32'(hi), 32'(e.len));
                    end
                    hi = 0;
                end
                prev = owSTART;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         r;
        #2 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_owSTART", 32'(owSTART), 32'd0);
            chk("rst_owData", 32'(owData), 32'd0);
            chk("rst_oRate", 32'(oRate), 32'd0);
        end
        reset = 1'b0;
        hold_line(1'b1, 2 * CPB);
        chk("idle_owSTART", 32'(owSTART), 32'd0);
        chk("idle_owData", 32'(owData), 32'd0);
        chk("idle_oRate", 32'(oRate), 32'd0);

        send_frame(8'h34, 1'b1, 20);
        send_frame(8'h4D, 1'b1, 20);
        send_frame(8'h35, 1'b1, 20);
        send_frame(8'h46, 1'b1, 0);
        send_frame(8'h34, 1'b1, 0);
        send_frame(8'h3F, 1'b1, 20);
        glitch(4);
        send_frame(8'h37, 1'b0, 20);
        send_frame(8'h32, 1'b1, 20);
        drain();

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                glitch(int'($urandom_range(1, 6)));
            end else begin
                b = (r < 5) ? 8'(32'h30 + $urandom_range(0, 9)) : 8'($urandom);
                send_frame(b, $urandom_range(0, 7) != 0, int'($urandom_range(0, 20)));
            end
        end
        drain();

        // Reset in the middle of a frame after a known good byte.
        send_frame(8'h37, 1'b1, 20);
        drain();
        hold_line(1'b0, CPB);
        hold_line(1'b1, CPB);
        hold_line(1'b0, CPB);
        hold_line(1'b1, HALF);
        reset = 1'b1;
        #1;
        chk("abort_owSTART", 32'(owSTART), 32'd0);
        chk("abort_owData", 32'(owData), 32'd0);
        chk("abort_oRate", 32'(oRate), 32'd0);
        m_data = 8'h00;
        m_rate = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        hold_line(1'b1, 2 * CPB);
        chk("post_abort_owData", 32'(owData), 32'd0);
        chk("post_abort_owSTART", 32'(owSTART), 32'd0);
        send_frame(8'h39, 1'b1, 20);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
